// File: rtl/pe_seq_pkg.sv
// Shared types and defaults for the PE array sequencer and its run counter.
package pe_seq_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

   localparam int CTRL_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;
   localparam int NUM_PE_DEF = 4;

   // A single PE still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_array_sequencer_run_counter.sv
// Saturating down-counter for the compute phase: load, decrement, zero flag.
module run_counter
   import pe_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - CNT_W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/pe_array_sequencer.sv
// Loads one control word per PE over a valid/ready stream, then enables the whole row for a
// programmed number of compute cycles and pulses done.
module pe_array_sequencer
   import pe_seq_pkg::*;
#(
   parameter int NUM_PE = NUM_PE_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  run_cycles,
   input  logic              abort,
   input  logic              cfg_valid,
   input  logic [CTRL_W-1:0] cfg_data,
   output logic              cfg_ready,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [NUM_PE-1:0] pe_en,
   output logic              busy,
   output logic              result_valid,
   output logic              done
);

   localparam int IDX_W = idx_width(NUM_PE);

   seq_state_t        state_reg;
   logic [IDX_W-1:0]  cfg_idx_reg;
   logic              run_en_reg;
   logic [NUM_PE-1:0] idx_onehot;
   logic              handshake;
   logic              last_pe;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;

   assign cfg_ready = (state_reg == LOAD);
   assign handshake = cfg_valid && cfg_ready;
   assign last_pe   = (cfg_idx_reg == IDX_W'(NUM_PE - 1));
   assign cnt_load  = (state_reg == IDLE) && start;
   assign cnt_dec   = (state_reg == RUN) && !abort && !cnt_zero;

   generate
      for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_onehot
         assign idx_onehot[gi] = (cfg_idx_reg == IDX_W'(gi));
      end
   endgenerate

   run_counter #(
      .CNT_W (CNT_W)
   ) u_run_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (run_cycles),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg    <= IDLE;
         cfg_idx_reg  <= '0;
         run_en_reg   <= 1'b0;
         ctrl_out     <= '0;
         pe_en        <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         pe_en        <= '0;
         run_en_reg   <= 1'b0;
         done         <= 1'b0;
         // Results appear one cycle after the operands are registered inside the PEs.
         result_valid <= run_en_reg;
         if (abort && (state_reg != IDLE)) begin
            state_reg    <= IDLE;
            cfg_idx_reg  <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (start) begin
                     cfg_idx_reg <= '0;
                     busy        <= 1'b1;
                     state_reg   <= LOAD;
                  end
               end
               LOAD: begin
                  if (handshake) begin
                     ctrl_out <= cfg_data;
                     pe_en    <= idx_onehot;
                     if (last_pe) begin
                        cfg_idx_reg <= '0;
                        state_reg   <= cnt_zero ? DONE : RUN;
                     end else begin
                        cfg_idx_reg <= cfg_idx_reg + IDX_W'(1);
                     end
                  end
               end
               RUN: begin
                  // One enable per remaining count; the zero check ends the phase.
                  if (!cnt_zero) begin
                     pe_en      <= '1;
                     run_en_reg <= 1'b1;
                  end else begin
                     state_reg <= DONE;
                  end
               end
               DONE: begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
